// File: rtl/sum_cla_seq.sv
// rtl/sum_cla_seq.sv - sequential WIDTH-bit adder/subtractor built on one 4-bit CLA slice
//
// Purpose: adds or subtracts two WIDTH-bit operands, one 4-bit group per clock,
// LSB group first. It uses a start/busy/done handshake.
//
// Ports:
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   launch request, sampled in IDLE only
//   sumar   in   add-mode select, sampled with start
//   restar  in   subtract-mode select, sampled with start
//   A, B    in   operands, sampled with start
//   c_in    in   carry-in for add mode, sampled with start
//   busy    out  computation in progress
//   done    out  one-cycle pulse, results valid from this cycle
//   S       out  result
//   c_out   out  carry out of MSB (no-borrow in subtract mode)
//   ovf     out  two's-complement overflow
//   zero    out  S == 0
module sum_cla_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sumar,
  input  logic             restar,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NG   = WIDTH / 4;
  localparam int IDXW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // effective B: B, ~B or 0 depending on mode
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;

  logic [IDXW+1:0]  w_base;
  logic [3:0]       w_ga;
  logic [3:0]       w_gb;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_gs;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_mode_add;
  logic             w_mode_sub;

  assign w_mode_add = sumar & ~restar;
  assign w_mode_sub = ~sumar & restar;

  // Bit offset of the group being processed.
  assign w_base = {r_idx, 2'b00};
  assign w_ga   = r_a[w_base +: 4];
  assign w_gb   = r_b[w_base +: 4];
  assign w_last = (r_idx == IDXW'(NG - 1));

  // 4-bit carry-lookahead slice.
  assign w_g    = w_ga & w_gb;
  assign w_p    = w_ga ^ w_gb;
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_gs   = w_p ^ w_c[3:0];

  // Accumulator with the current group merged in; the final transfer to S
  // must include the last group computed on that same edge.
  always_comb begin
    w_acc_next               = r_acc;
    w_acc_next[w_base +: 4]  = w_gs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      S       <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_idx <= '0;
            // Subtract is A + ~B + 1; invalid modes reduce to A + 0 + 0.
            if (w_mode_add) begin
              r_b     <= B;
              r_carry <= c_in;
            end else if (w_mode_sub) begin
              r_b     <= ~B;
              r_carry <= 1'b1;
            end else begin
              r_b     <= '0;
              r_carry <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_c[4];
          if (w_last) begin
            r_idx <= '0;
            S     <= w_acc_next;
            c_out <= w_c[4];
            ovf   <= w_c[3] ^ w_c[4];
            zero  <= (w_acc_next == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_cla_seq.sv
// tb/tb_sum_cla_seq.sv - scoreboard bench for sum_cla_seq at WIDTH 4, 16 and 32
module tb_sum_cla_seq;

  logic        clk;
  logic        rst_n;
  logic        start4, start16, start32;
  logic        sumar_d, restar_d, c_in_d;
  logic [31:0] a_d, b_d;

  logic        busy4, done4, c4, o4, z4;
  logic [3:0]  s4;
  logic        busy16, done16, c16, o16, z16;
  logic [15:0] s16;
  logic        busy32, done32, c32, o32, z32;
  logic [31:0] s32;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          at;
  } exp_t;

  exp_t q4[$];
  exp_t q16[$];
  exp_t q32[$];

  sum_cla_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sumar(sumar_d), .restar(restar_d),
    .A(a_d[3:0]), .B(b_d[3:0]), .c_in(c_in_d), .busy(busy4), .done(done4),
    .S(s4), .c_out(c4), .ovf(o4), .zero(z4)
  );

  sum_cla_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sumar(sumar_d), .restar(restar_d),
    .A(a_d[15:0]), .B(b_d[15:0]), .c_in(c_in_d), .busy(busy16), .done(done16),
    .S(s16), .c_out(c16), .ovf(o16), .zero(z16)
  );

  sum_cla_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sumar(sumar_d), .restar(restar_d),
    .A(a_d), .B(b_d), .c_in(c_in_d), .busy(busy32), .done(done32),
    .S(s32), .c_out(c32), .ovf(o32), .zero(z32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input logic [31:0] s,
                              input logic c, input logic o, input logic z, input logic b);
    cmp({tag, "_S"}, s, e.s);
    cmp({tag, "_c_out"}, {31'b0, c}, {31'b0, e.c});
    cmp({tag, "_ovf"}, {31'b0, o}, {31'b0, e.o});
    cmp({tag, "_zero"}, {31'b0, z}, {31'b0, e.z});
    cmp({tag, "_done_cycle"}, cyc, e.at);
    cmp({tag, "_busy_with_done"}, {31'b0, b}, 32'd0);
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_done: got done=1 expected no pending result (t=%0t)", tag, $time);
  endtask

  // Monitors: pop and compare whenever a DUT presents done.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) unexpected("w4");
      else check_result("w4", q4.pop_front(), {28'b0, s4}, c4, o4, z4, busy4);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (q16.size() == 0) unexpected("w16");
      else check_result("w16", q16.pop_front(), {16'b0, s16}, c16, o16, z16, busy16);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) unexpected("w32");
      else check_result("w32", q32.pop_front(), s32, c32, o32, z32, busy32);
    end
  end

  function automatic int ng_of(input int w);
    return w / 4;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 4) start4 = v;
    else if (w == 16) start16 = v;
    else start32 = v;
  endtask

  task automatic push_exp(input int w, input exp_t e);
    if (w == 4) q4.push_back(e);
    else if (w == 16) q16.push_back(e);
    else q32.push_back(e);
  endtask

  // Raise start before edge 0, keep it for nops launches, then scramble the
  // inputs so that anything sampled after capture would corrupt the result.
  task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic rs, input logic ci,
                       input logic [31:0] es, input logic ec, input logic eo,
                       input logic ez, input int nops);
    exp_t e;
    int   ng;
    ng = ng_of(w);
    @(negedge clk);
    a_d = a; b_d = b; sumar_d = sm; restar_d = rs; c_in_d = ci;
    set_start(w, 1'b1);
    for (int k = 0; k < nops; k++) begin
      e.s = es; e.c = ec; e.o = eo; e.z = ez;
      e.at = cyc + 1 + ng + k * (ng + 2);
      push_exp(w, e);
    end
    repeat (1 + (nops - 1) * (ng + 2)) @(negedge clk);
    set_start(w, 1'b0);
    a_d = ~a; b_d = $urandom; sumar_d = ~sm; restar_d = ~rs; c_in_d = ~ci;
  endtask

  task automatic settle(input int w);
    repeat (ng_of(w) + 2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; start16 = 1'b0; start32 = 1'b0;
    sumar_d = 1'b0; restar_d = 1'b0; c_in_d = 1'b0;
    a_d = '0; b_d = '0;

    repeat (2) @(negedge clk);
    cmp("reset_S16", {16'b0, s16}, 32'd0);
    cmp("reset_flags16", {28'b0, busy16, done16, c16, o16 | z16}, 32'd0);
    rst_n = 1'b1;

    // First add with explicit busy/done timing: busy after edges 0..3, done after edge 4.
    issue(16, 32'h1234, 32'h4321, 1'b1, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      cmp("timing_busy_run", {31'b0, busy16}, 32'd1);
      cmp("timing_done_run", {31'b0, done16}, 32'd0);
      @(negedge clk);
    end
    cmp("timing_busy_done", {31'b0, busy16}, 32'd0);
    cmp("timing_done_pulse", {31'b0, done16}, 32'd1);
    @(negedge clk);
    cmp("timing_done_drop", {31'b0, done16}, 32'd0);
    cmp("hold_S", {16'b0, s16}, 32'h5555);
    settle(16);

    issue(16, 32'hFFFF, 32'h0001, 1'b1, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1, 1); settle(16);
    issue(16, 32'h7FFF, 32'h0000, 1'b1, 1'b0, 1'b1, 32'h8000, 1'b0, 1'b1, 1'b0, 1); settle(16);
    issue(16, 32'h0005, 32'h0007, 1'b0, 1'b1, 1'b0, 32'hFFFE, 1'b0, 1'b0, 1'b0, 1); settle(16);
    issue(16, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0, 1); settle(16);
    issue(16, 32'h1234, 32'h1234, 1'b0, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1, 1); settle(16);
    issue(16, 32'hABCD, 32'h1111, 1'b1, 1'b1, 1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0, 1); settle(16);
    issue(16, 32'hABCD, 32'h1111, 1'b0, 1'b0, 1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0, 1); settle(16);

    // Start pulses during RUN and DONE must be ignored.
    issue(16, 32'h1111, 32'h2222, 1'b1, 1'b0, 1'b0, 32'h3333, 1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    a_d = 32'h0F0F; b_d = 32'h0101; sumar_d = 1'b1; restar_d = 1'b0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    settle(16);

    // start held high: three launches six cycles apart.
    issue(16, 32'h0100, 32'h0200, 1'b1, 1'b0, 1'b0, 32'h0300, 1'b0, 1'b0, 1'b0, 3);
    settle(16);

    // Reset after edge 2 of a full-ripple add: aborted, no done.
    @(negedge clk);
    a_d = 32'hFFFF; b_d = 32'h0001; sumar_d = 1'b1; restar_d = 1'b0; c_in_d = 1'b0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp("abort_busy_before", {31'b0, busy16}, 32'd1);
    rst_n = 1'b0;
    #1;
    cmp("abort_S", {16'b0, s16}, 32'd0);
    cmp("abort_busy", {31'b0, busy16}, 32'd0);
    cmp("abort_done", {31'b0, done16}, 32'd0);
    cmp("abort_flags", {29'b0, c16, o16, z16}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(16, 32'h0001, 32'h0001, 1'b1, 1'b0, 1'b0, 32'h0002, 1'b0, 1'b0, 1'b0, 1); settle(16);

    // WIDTH = 4
    issue(4, 32'hF, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1); settle(4);
    issue(4, 32'h7, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1); settle(4);
    issue(4, 32'h5, 32'h7, 1'b0, 1'b1, 1'b0, 32'hE, 1'b0, 1'b0, 1'b0, 1); settle(4);
    issue(4, 32'hB, 32'h1, 1'b1, 1'b1, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1); settle(4);
    issue(4, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0, 3); settle(4);

    // WIDTH = 32
    issue(32, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1); settle(32);
    issue(32, 32'h80000000, 32'h1, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1); settle(32);
    issue(32, 32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1); settle(32);
    issue(32, 32'hDEADBEEF, 32'h1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1); settle(32);

    repeat (4) @(negedge clk);
    cmp("pending_w4", q4.size(), 32'd0);
    cmp("pending_w16", q16.size(), 32'd0);
    cmp("pending_w32", q32.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
